btn_event_arbiter: RTL

//  Collects single-cycle press pulses from N_BTN button shapers and holds each
//  one as a pending request. A round-robin arbiter grants one pending button per

---
 rtl/btn_event_arbiter_if.sv | 21 ++
 rtl/btn_event_arbiter.sv | 66 ++++++
 2 files changed

// File: rtl/btn_event_arbiter_if.sv
// btn_event_arbiter_if: button pulse inputs and the event valid/ready stream of btn_event_arbiter.
// DropCnt exists only when BTN_ARB_DROPCNT_EN is defined.
interface btn_event_arbiter_if #(
   parameter int N_BTN = 4,
   parameter int IDW = 2
);
   logic [N_BTN-1:0] BtnPulse;
   logic             EvReady;
   logic             EvValid;
   logic [IDW-1:0]   EvId;
   logic [N_BTN-1:0] Pending;
   logic             Full;
`ifdef BTN_ARB_DROPCNT_EN
   logic [7:0]       DropCnt;
   modport slave (input BtnPulse, EvReady, output EvValid, EvId, Pending, Full, DropCnt);
   modport master (output BtnPulse, EvReady, input EvValid, EvId, Pending, Full, DropCnt);
`else
   modport slave (input BtnPulse, EvReady, output EvValid, EvId, Pending, Full);
   modport master (output BtnPulse, EvReady, input EvValid, EvId, Pending, Full);
`endif
endinterface

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: latches button press pulses, grants them round-robin into an event FIFO.
// Define BTN_ARB_DROPCNT_EN to add the saturating merged-press counter DropCnt.
module btn_event_arbiter #(
   parameter int N_BTN = 4,
   parameter int IDW = 2,
   parameter int DEPTH = 4,
   parameter int PW = 2
) (
   input logic Clk,
   input logic Rst,
   btn_event_arbiter_if.slave bus
);
   logic [N_BTN-1:0] pending, clr;
   logic [IDW-1:0]   rr_ptr, winner, idx;
   logic [IDW-1:0]   mem [DEPTH];
   logic [PW-1:0]    rd, wr;
   logic [PW:0]      count;
   logic             found, full, grant, pop;
   // idx wraps explicitly so non power-of-2 N_BTN never searches a missing bit
   always_comb begin
      winner = '0;
      found = 1'b0;
      idx = rr_ptr;
      for (int k = 0; k < N_BTN; k++) begin
         if (!found && pending[idx]) begin
            winner = idx;
            found = 1'b1;
         end
         idx = (idx == IDW'(N_BTN - 1)) ? '0 : idx + 1'b1;
      end
   end
   assign full = count == (PW+1)'(DEPTH);
   assign grant = found && !full;
   assign pop = (count != '0) && bus.EvReady;
   assign clr = grant ? (N_BTN'(1) << winner) : '0;
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         pending <= '0;
         rr_ptr <= '0;
         rd <= '0;
         wr <= '0;
         count <= '0;
      end else begin
         pending <= (pending & ~clr) | bus.BtnPulse;
         if (grant) begin
            wr <= wr + 1'b1;
            rr_ptr <= (winner == IDW'(N_BTN - 1)) ? '0 : winner + 1'b1;
         end
         if (pop) rd <= rd + 1'b1;
         count <= count + (PW+1)'(grant) - (PW+1)'(pop);
      end
   end
   always_ff @(posedge Clk)
      if (Rst && grant) mem[wr] <= winner;
   assign bus.EvValid = count != '0;
   assign bus.EvId = (count != '0) ? mem[rd] : '0;
   assign bus.Pending = pending;
   assign bus.Full = full;
`ifdef BTN_ARB_DROPCNT_EN
   logic [7:0] drop_cnt;
   always_ff @(posedge Clk)
      if (!Rst) drop_cnt <= '0;
      else if (|(bus.BtnPulse & pending & ~clr) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
   assign bus.DropCnt = drop_cnt;
`endif
endmodule
